// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types, widths and helpers for memory port arbiters
package mem_arb_pkg;

  localparam int PERF_CNT_W = 32;
  localparam int MAX_REQ    = 16;
  localparam int REQ_IDX_W  = 4;

  // Index width for n requesters; never below one bit so a 1-bit pointer still exists
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  typedef logic [REQ_IDX_W-1:0] req_idx_t;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker starting at rr_ptr
module rr_pick
  import mem_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req_valid,
  input  logic [IW-1:0] rr_ptr,
  output logic [N-1:0]  grant_oh,
  output logic [IW-1:0] grant_idx,
  output logic          any_grant
);

  // Walk rr_ptr, rr_ptr+1, ... with an explicit wrap so N need not be a power of two
  always_comb begin
    int cand;
    grant_oh  = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    cand      = 0;
    for (int k = 0; k < N; k++) begin
      cand = int'(rr_ptr) + k;
      if (cand >= N) cand = cand - N;
      if (!any_grant && req_valid[cand[IW-1:0]]) begin
        any_grant                 = 1'b1;
        grant_idx                 = cand[IW-1:0];
        grant_oh[cand[IW-1:0]]    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin share of one main_memory port; optional counters via MEM_PORT_ARBITER_PERF_EN
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [N_REQ-1:0]      req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr  [N_REQ],
  input  logic [DATA_WIDTH-1:0] req_wdata [N_REQ],
  output logic [N_REQ-1:0]      req_ready,
  output logic [N_REQ-1:0]      rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [ADDR_WIDTH-1:0] mem_read_addr,
  output logic [ADDR_WIDTH-1:0] mem_write_addr,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  output logic                  mem_write_ctrl,
  input  logic [DATA_WIDTH-1:0] mem_read_out
`ifdef MEM_PORT_ARBITER_PERF_EN
  ,
  output logic [PERF_CNT_W-1:0] perf_grants [N_REQ],
  output logic [PERF_CNT_W-1:0] perf_conflict_cycles
`endif
);

  localparam int IW = idx_w(N_REQ);

  logic [IW-1:0]    rr_ptr;
  logic [IW-1:0]    rsp_idx;
  logic             rsp_pend;
  logic [N_REQ-1:0] grant_oh;
  logic [IW-1:0]    grant_idx;
  logic             any_grant;
  logic             accept;

  rr_pick #(
    .N  (N_REQ),
    .IW (IW)
  ) u_pick (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr),
    .grant_oh  (grant_oh),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  // Nothing is accepted or written while reset is held
  assign accept    = any_grant & reset_n;
  assign rsp_rdata = mem_read_out;

  // Drive the granted requester onto the memory port; idle port reads as all zeros
  always_comb begin
    req_ready      = reset_n ? grant_oh : '0;
    mem_read_addr  = '0;
    mem_write_addr = '0;
    mem_write_data = '0;
    mem_write_ctrl = 1'b0;
    if (accept) begin
      mem_read_addr  = req_addr[grant_idx];
      mem_write_addr = req_addr[grant_idx];
      mem_write_data = req_wdata[grant_idx];
      mem_write_ctrl = req_write[grant_idx];
    end
  end

  // Return the registered read to whoever issued it; a reset in flight drops it
  always_comb begin
    rsp_valid = '0;
    if (rsp_pend && reset_n) rsp_valid[rsp_idx] = 1'b1;
  end

  // Advance the pointer past the winner and remember a granted read for one cycle
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rr_ptr   <= '0;
      rsp_pend <= 1'b0;
      rsp_idx  <= '0;
    end else begin
      rsp_pend <= accept & ~req_write[grant_idx];
      if (accept) begin
        rr_ptr  <= (grant_idx == IW'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
        rsp_idx <= grant_idx;
      end
    end
  end

`ifdef MEM_PORT_ARBITER_PERF_EN
  // Free-running grant and contention counters, wrapping naturally
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < N_REQ; i++) perf_grants[i] <= '0;
      perf_conflict_cycles <= '0;
    end else begin
      if (accept) perf_grants[grant_idx] <= perf_grants[grant_idx] + 1'b1;
      if ($countones(req_valid) >= 2) perf_conflict_cycles <= perf_conflict_cycles + 1'b1;
    end
  end
`endif

endmodule
